// File: rtl/mul_sched_arb.sv
// Round-robin arbiter/sequencer that shares one repeated-addition multiplier
// datapath between two requesters and returns the product with a done pulse.
module mul_sched_arb #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] res_o,
  output logic             busy_o,
  input  logic             dp_eq_i,
  input  logic [WIDTH-1:0] dp_prod_i,
  output logic [WIDTH-1:0] dp_datain_c_o,
  output logic             lda_c_o,
  output logic             ldb_c_o,
  output logic             ldp_c_o,
  output logic             clrp_c_o,
  output logic             decb_c_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_ADD  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q;
  logic             owner_q;
  logic             prio_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic [WIDTH-1:0] res_q;
  logic             busy_q;
  logic             owner_d;

  // Arbitration pick: priority holder under contention, else the lone requester
  always_comb begin
    owner_d = req_i[1];
    if (&req_i) owner_d = prio_q;
  end

  // Sequencer FSM with registered grant/done/result/busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      res_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            owner_q <= owner_d;
            prio_q  <= ~owner_d;
            gnt_q   <= owner_d ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= S_LDA;
          end
        end
        S_LDA: state_q <= S_LDB;
        S_LDB: state_q <= S_ADD;
        S_ADD: begin
          if (dp_eq_i) begin
            res_q   <= dp_prod_i;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath strobes and operand mux decoded from the current state and owner
  always_comb begin
    dp_datain_c_o = '0;
    lda_c_o       = 1'b0;
    ldb_c_o       = 1'b0;
    ldp_c_o       = 1'b0;
    clrp_c_o      = 1'b0;
    decb_c_o      = 1'b0;
    case (state_q)
      S_LDA: begin
        dp_datain_c_o = owner_q ? a1_i : a0_i;
        lda_c_o       = 1'b1;
      end
      S_LDB: begin
        dp_datain_c_o = owner_q ? b1_i : b0_i;
        ldb_c_o       = 1'b1;
        clrp_c_o      = 1'b1;
      end
      S_ADD: begin
        ldp_c_o  = ~dp_eq_i;
        decb_c_o = ~dp_eq_i;
      end
      default: ;
    endcase
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign res_o  = res_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_mul_sched_arb.sv
// Bench for mul_sched_arb: behavioural datapath, expected-result scoreboard.
module tb_mul_sched_arb;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [1:0]       gnt;
    logic [WIDTH-1:0] res;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0]       gnt, done;
  logic [WIDTH-1:0] res;
  logic             busy;
  logic             dp_eq;
  logic [WIDTH-1:0] dp_prod;
  logic [WIDTH-1:0] dp_datain;
  logic             lda, ldb, ldp, clrp, decb;

  logic [WIDTH-1:0] dp_a = '0;
  logic [WIDTH-1:0] dp_b = '0;
  logic [WIDTH-1:0] dp_p = '0;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   grant_cyc = 0;
  int   done_cnt = 0;
  int   bad_gnt = 0, bad_pulse = 0, bad_done = 0;
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] prev_done = 2'b00;

  mul_sched_arb #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req),
    .a0_i          (a0),
    .b0_i          (b0),
    .a1_i          (a1),
    .b1_i          (b1),
    .gnt_o         (gnt),
    .done_o        (done),
    .res_o         (res),
    .busy_o        (busy),
    .dp_eq_i       (dp_eq),
    .dp_prod_i     (dp_prod),
    .dp_datain_c_o (dp_datain),
    .lda_c_o       (lda),
    .ldb_c_o       (ldb),
    .ldp_c_o       (ldp),
    .clrp_c_o      (clrp),
    .decb_c_o      (decb)
  );

  always #5 clk = ~clk;

  // Behavioural datapath
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (lda)  dp_a <= dp_datain;
    if (ldb)  dp_b <= dp_datain;
    if (decb) dp_b <= dp_b - 1'b1;
    if (clrp) dp_p <= '0;
    if (ldp)  dp_p <= dp_p + dp_a;
  end
  assign dp_eq   = (dp_b == '0);
  assign dp_prod = dp_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_op(input int who, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] p;
    p     = a * b;
    e.gnt = (who == 1) ? 2'b10 : 2'b01;
    e.res = p;
    e.lat = int'(b) + 3;
    exp_q.push_back(e);
  endtask

  task automatic wait_more(input int n);
    int tgt;
    int k;
    tgt = done_cnt + n;
    k   = 0;
    while (done_cnt < tgt && k < 200 * n) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt < tgt) check("done_timeout", 64'(done_cnt), 64'(tgt));
  endtask

  // Monitor: grant timing, protocol sanity, scoreboard compare on done
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_gnt  = 2'b00;
      prev_done = 2'b00;
    end else begin
      if (prev_gnt == 2'b00 && gnt != 2'b00) grant_cyc = cyc;
      if (gnt == 2'b11) bad_gnt++;
      if (done != 2'b00 && prev_done != 2'b00) bad_pulse++;
      if (done != 2'b00 && done != gnt) bad_done++;
      if (done != 2'b00) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'(done), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("done_who", 64'(done), 64'(e.gnt));
          check("gnt_at_done", 64'(gnt), 64'(e.gnt));
          check("res", 64'(res), 64'(e.res));
          check("latency", 64'(cyc - grant_cyc), 64'(e.lat));
        end
      end
      prev_gnt  = gnt;
      prev_done = done;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_strobes"}, 64'({lda, ldb, ldp, clrp, decb}), 64'(0));
    check({tag, "_datain"}, 64'(dp_datain), 64'(0));
  endtask

  initial begin
    int k;
    rst = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_res", 64'(res), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: lone requester 0, 16*5
    a0 = 32'd16; b0 = 32'd5; expect_op(0, a0, b0);
    req = 2'b01;
    wait_more(1);
    req = 2'b00;
    repeat (2) @(negedge clk);
    check("t1_busy_after", 64'(busy), 64'(0));

    // 2: contention straight after reset, requester 0 first
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    a0 = 32'd3; b0 = 32'd4; a1 = 32'd7; b1 = 32'd2;
    expect_op(0, a0, b0); expect_op(1, a1, b1);
    req = 2'b11;
    wait_more(1);
    req[0] = 1'b0;
    wait_more(1);
    req = 2'b00;
    @(negedge clk);

    // 3: both held for four operations, grants alternate
    a0 = 32'd5; b0 = 32'd3; a1 = 32'd6; b1 = 32'd1;
    expect_op(0, a0, b0); expect_op(1, a1, b1);
    expect_op(0, a0, b0); expect_op(1, a1, b1);
    req = 2'b11;
    wait_more(4);
    req = 2'b00;
    @(negedge clk);

    // 4: zero repeat count and zero multiplicand
    a1 = 32'd9; b1 = 32'd0; expect_op(1, a1, b1);
    req = 2'b10;
    wait_more(1);
    req = 2'b00;
    @(negedge clk);
    a0 = 32'd0; b0 = 32'd6; expect_op(0, a0, b0);
    req = 2'b01;
    wait_more(1);
    req = 2'b00;
    @(negedge clk);

    // 5: product wraps
    a0 = 32'hFFFF_FFFF; b0 = 32'd2; expect_op(0, a0, b0);
    req = 2'b01;
    wait_more(1);
    req = 2'b00;
    @(negedge clk);

    // 6: reset during ADD aborts, then contention resolves to requester 0
    a0 = 32'd3; b0 = 32'd10;
    req = 2'b01;
    k = 0;
    while (gnt == 2'b00 && k < 20) begin @(negedge clk); k++; end
    check("t6_granted", 64'(gnt), 64'(2'b01));
    repeat (5) @(negedge clk);
    check("t6_in_add_ldp", 64'(ldp), 64'(1));
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    req = 2'b00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    a0 = 32'd4; b0 = 32'd3; a1 = 32'd2; b1 = 32'd2;
    expect_op(0, a0, b0); expect_op(1, a1, b1);
    req = 2'b11;
    wait_more(1);
    req[0] = 1'b0;
    wait_more(1);
    req = 2'b00;
    repeat (4) @(negedge clk);

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    check("gnt_onehot_violations", 64'(bad_gnt), 64'(0));
    check("done_pulse_violations", 64'(bad_pulse), 64'(0));
    check("done_vs_gnt_violations", 64'(bad_done), 64'(0));
    check("total_dones", 64'(done_cnt), 64'(12));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
